// File: rtl/valve_driver_multi.sv
// Multi-channel valve pulse-train driver: one shared timing engine fires N pulses
// on the channels selected by a mask, with gap, abort and busy/done status.

module valve_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic mask_bit,
  output logic out
);
  logic out_q, out_d;

  always_comb begin
    out_d = out_q;
    if (clr)       out_d = 1'b0;
    else if (load) out_d = mask_bit;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_q <= 1'b0;
    else        out_q <= out_d;

  assign out = out_q;
endmodule

module valve_driver_multi #(
  parameter int NUM_CH      = 4,
  parameter int DUR_W       = 24,
  parameter int REP_W       = 4,
  parameter int DEFAULT_GAP = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [DUR_W-1:0]  duration,
  input  logic [DUR_W-1:0]  gap,
  input  logic [REP_W-1:0]  repeats,
  output logic [NUM_CH-1:0] valve_out,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;

  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [DUR_W-1:0] DEF_GAP = DUR_W'(DEFAULT_GAP);

  state_t              state_q, state_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [REP_W-1:0]    pcnt_q, pcnt_d;
  logic [NUM_CH-1:0]   mask_s_q, mask_s_d;
  logic [DUR_W-1:0]    dur_s_q, dur_s_d;
  logic [DUR_W-1:0]    gap_s_q, gap_s_d;
  logic [REP_W-1:0]    rep_s_q, rep_s_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                load, clr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    mask_s_d  = mask_s_q;
    dur_s_d   = dur_s_q;
    gap_s_d   = gap_s_q;
    rep_s_d   = rep_s_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    load      = 1'b0;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger && !abort) begin
          mask_s_d  = ch_mask;
          dur_s_d   = duration;
          gap_s_d   = (gap == '0) ? DEF_GAP : gap;
          rep_s_d   = repeats;
          cnt_d     = '0;
          pcnt_d    = '0;
          aborted_d = 1'b0;
          if (repeats == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        if (abort) begin
          clr = 1'b1; aborted_d = 1'b1; done_d = 1'b1; state_d = S_DONE;
        end else if (cnt_q == dur_s_q) begin
          clr = 1'b1; cnt_d = '0; state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + DUR_ONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          clr = 1'b1; aborted_d = 1'b1; done_d = 1'b1; state_d = S_DONE;
        end else if (cnt_q == gap_s_q) begin
          // trailing gap doubles as lockout before reporting done
          if (pcnt_q == rep_s_q - REP_ONE) begin
            done_d = 1'b1; state_d = S_DONE;
          end else begin
            pcnt_d = pcnt_q + REP_ONE; cnt_d = '0; load = 1'b1; state_d = S_PULSE;
          end
        end else begin
          cnt_d = cnt_q + DUR_ONE;
        end
      end
      S_DONE: if (!trigger) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_PULSE) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      mask_s_q  <= '0;
      dur_s_q   <= '0;
      gap_s_q   <= '0;
      rep_s_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      mask_s_q  <= mask_s_d;
      dur_s_q   <= dur_s_d;
      gap_s_q   <= gap_s_d;
      rep_s_q   <= rep_s_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // each lane reloads from the mask being latched this cycle (or the shadow copy)
  valve_lane u_lane [NUM_CH-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .clr      (clr),
    .mask_bit (mask_s_d),
    .out      (valve_out)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
endmodule

// File: tb/tb_valve_driver_multi.sv
// Directed bench for valve_driver_multi: table of train scenarios plus
// hand-written sequences for held trigger, abort, reset and default gap.

module tb_valve_driver_multi;
  logic        clk = 1'b0;
  logic        rst_n, trigger, abort;
  logic [3:0]  ch_mask;
  logic [23:0] duration, gap;
  logic [3:0]  repeats;
  logic [3:0]  valve_out;
  logic        busy, done, aborted;

  valve_driver_multi #(.NUM_CH(4), .DUR_W(24), .REP_W(4), .DEFAULT_GAP(50000)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .abort(abort), .ch_mask(ch_mask),
    .duration(duration), .gap(gap), .repeats(repeats), .valve_out(valve_out),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Load inputs, pulse trigger for one sampling edge, then scramble inputs.
  task automatic start(input logic [3:0] m, input int d, input int g, input int r);
    @(negedge clk);
    ch_mask = m; duration = 24'(d); gap = 24'(g); repeats = 4'(r); trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    ch_mask = ~m; duration = 24'd7; gap = 24'd7; repeats = 4'd9;
  endtask

  // Sample `limit` negedges after the trigger edge; k=1 is the first cycle after it.
  task automatic measure(input logic [3:0] m, input int exp_hi, input int exp_lo,
                         input int limit, output int pulses, output int hi_bad,
                         output int lo_bad, output int done_k, output int done_cnt,
                         output int busy_cnt, output int mask_bad);
    int run;
    logic [3:0] prev;
    prev = '0; run = 0; pulses = 0; hi_bad = 0; lo_bad = 0;
    done_k = -1; done_cnt = 0; busy_cnt = 0; mask_bad = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (valve_out != 4'd0 && valve_out != m) mask_bad++;
      if ((valve_out != 4'd0) != (prev != 4'd0)) begin
        if (prev == 4'd0) begin
          pulses++;
          if (pulses > 1 && run != exp_lo) lo_bad++;
        end else if (run != exp_hi) hi_bad++;
        run = 1;
      end else run++;
      prev = valve_out;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
    end
  endtask

  typedef struct {
    logic [3:0] mask;
    int dur, gp, reps;
    int exp_pulses, exp_hi, exp_lo, exp_done_k, exp_busy;
  } vec_t;

  vec_t vecs[6];
  int p, hb, lb, dk, dc, bc, mb, lo;

  initial begin
    vecs[0] = '{4'b0101, 9, 4, 3,  3, 10, 5, 46, 45};
    vecs[1] = '{4'b1111, 0, 1, 2,  2, 1,  2, 7,  6};
    vecs[2] = '{4'b0000, 3, 2, 2,  0, 0,  0, 15, 14};
    vecs[3] = '{4'b1111, 5, 3, 0,  0, 0,  0, 1,  0};
    vecs[4] = '{4'b1010, 1, 1, 15, 15, 2, 2, 61, 60};
    vecs[5] = '{4'b0011, 2, 6, 1,  1, 3,  0, 11, 10};

    rst_n = 1'b0; trigger = 1'b0; abort = 1'b0;
    ch_mask = '0; duration = '0; gap = '0; repeats = '0;
    repeat (3) @(negedge clk);
    check("rst_valve", int'(valve_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      start(vecs[i].mask, vecs[i].dur, vecs[i].gp, vecs[i].reps);
      measure(vecs[i].mask, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_done_k + 3,
              p, hb, lb, dk, dc, bc, mb);
      check($sformatf("v%0d_pulses", i), p, vecs[i].exp_pulses);
      check($sformatf("v%0d_hi_len_bad", i), hb, 0);
      check($sformatf("v%0d_lo_len_bad", i), lb, 0);
      check($sformatf("v%0d_done_cycle", i), dk, vecs[i].exp_done_k);
      check($sformatf("v%0d_done_strobes", i), dc, 1);
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      check($sformatf("v%0d_mask_bad", i), mb, 0);
      check($sformatf("v%0d_aborted", i), int'(aborted), 0);
    end

    // trigger held high: exactly one train until it drops and rises again
    @(negedge clk);
    ch_mask = 4'b0010; duration = 24'd4; gap = 24'd2; repeats = 4'd1; trigger = 1'b1;
    measure(4'b0010, 5, 0, 200, p, hb, lb, dk, dc, bc, mb);
    check("held_pulses", p, 1);
    check("held_hi_len_bad", hb, 0);
    check("held_done_cycle", dk, 9);
    check("held_done_strobes", dc, 1);
    trigger = 1'b0;
    measure(4'b0010, 5, 0, 5, p, hb, lb, dk, dc, bc, mb);
    check("held_release_pulses", p, 0);
    start(4'b0010, 4, 2, 1);
    measure(4'b0010, 5, 0, 12, p, hb, lb, dk, dc, bc, mb);
    check("retrig_pulses", p, 1);
    check("retrig_done_cycle", dk, 9);

    // abort in 3rd cycle of pulse 2 of 4
    start(4'b1111, 9, 4, 4);
    repeat (18) @(negedge clk);
    check("abort_pre_valve", int'(valve_out), 15);
    abort = 1'b1;
    @(negedge clk);
    check("abort_valve", int'(valve_out), 0);
    check("abort_aborted", int'(aborted), 1);
    check("abort_done", int'(done), 1);
    check("abort_busy", int'(busy), 0);
    abort = 1'b0;
    @(negedge clk);
    check("abort_done_once", int'(done), 0);
    check("abort_sticky", int'(aborted), 1);
    start(4'b0001, 1, 1, 1);
    @(negedge clk);
    check("abort_clear_on_start", int'(aborted), 0);
    check("abort_restart_valve", int'(valve_out), 1);
    measure(4'b0001, 2, 0, 6, p, hb, lb, dk, dc, bc, mb);
    check("abort_restart_done", dk, 4);

    // abort together with trigger in IDLE: nothing starts
    @(negedge clk);
    ch_mask = 4'b1111; duration = 24'd3; gap = 24'd1; repeats = 4'd1;
    trigger = 1'b1; abort = 1'b1;
    measure(4'b1111, 4, 0, 3, p, hb, lb, dk, dc, bc, mb);
    check("idle_abort_pulses", p, 0);
    check("idle_abort_busy", bc, 0);
    check("idle_abort_done", dc, 0);
    trigger = 1'b0; abort = 1'b0;

    // abort while sitting in DONE has no effect
    @(negedge clk);
    ch_mask = 4'b0001; duration = 24'd0; gap = 24'd1; repeats = 4'd1; trigger = 1'b1;
    repeat (4) @(negedge clk);
    check("done_hold_strobe", int'(done), 1);
    abort = 1'b1;
    @(negedge clk);
    check("done_abort_aborted", int'(aborted), 0);
    check("done_abort_busy", int'(busy), 0);
    abort = 1'b0; trigger = 1'b0;
    repeat (2) @(negedge clk);

    // asynchronous reset mid-pulse
    start(4'b1111, 20, 1, 1);
    repeat (5) @(negedge clk);
    check("rstmid_pre_valve", int'(valve_out), 15);
    rst_n = 1'b0;
    #1;
    check("rstmid_valve_async", int'(valve_out), 0);
    check("rstmid_busy_async", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmid_idle_valve", int'(valve_out), 0);
    start(4'b0100, 2, 1, 1);
    measure(4'b0100, 3, 0, 8, p, hb, lb, dk, dc, bc, mb);
    check("rstmid_new_pulses", p, 1);
    check("rstmid_new_hi_bad", hb, 0);
    check("rstmid_new_done", dk, 6);

    // gap=0 selects the default gap; measure one gap then abort
    start(4'b0001, 0, 0, 2);
    @(negedge clk);
    check("dgap_first_pulse", int'(valve_out), 1);
    lo = 0;
    for (int k = 0; k < 50100; k++) begin
      @(negedge clk);
      if (valve_out != 4'd0) break;
      lo++;
    end
    check("dgap_low_cycles", lo, 50001);
    abort = 1'b1;
    @(negedge clk);
    check("dgap_abort_done", int'(done), 1);
    check("dgap_abort_valve", int'(valve_out), 0);
    abort = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
